adc_capture_core: RTL and testbench
===================================

// Module: adc_capture_core
// PURPOSE
//  Capture/packetizer engine of the ADC capture chip: on a start/again request it streams TOTAL_SAMPLES
//  18-bit samples (ADC input or self-test ramp) to the ADC_DATA pads. Output is in packets of data beats
//  separated by idle beats, paced by a programmable beat divider, with a companion read strobe CLK_RD.
//  Sits between the register file (cfg_* inputs) and the pad ring.
// PARAMETERS
//  DATA_W         18    sample / pad data width
//  TOTAL_SAMPLES  4096  data beats per capture run (>=1)
// PORTS
//  clk              in   1       single core clock
//  rst              in   1       synchronous, active-high reset
//  adc_in           in   DATA_W  raw ADC sample, sampled on data beats when self-test is off
//  cfg_clk_en       in   1       1 = engine runs; 0 = all state frozen, outputs held
//  cfg_sw_rstn      in   1       0 = soft reset, same effect as rst (synchronous)
//  cfg_self_test    in   1       1 = sample source is internal ramp
//  cfg_start        in   1       level; rising edge requests a fresh capture
//  cfg_again        in   1       level; rising edge requests a repeat capture
//  cfg_gap          in   8       beat divider: one beat every max(gap,1)+1 clk cycles
//  cfg_data_len     in   16      data beats per packet = data_len+1
//  cfg_idle_len     in   16      idle beats after each packet = idle_len
//  adc_data         out  DATA_W  pad data, registered
//  adc_data_valid   out  1       high during data beats, registered
//  clk_rd           out  1       read strobe, registered
//  capture_busy     out  1       capture in progress
//  capture_done     out  1       sticky: last run completed; cleared by next start/again
// BEHAVIOUR
//  - Reset (rst | !cfg_sw_rstn): all outputs 0, FSM IDLE, divider=0, ramp=0, edge regs=0, sample count=0.
//  - Edge detect: start_p/again_p = input & ~registered previous value (1-cycle pulse, 1 cycle latency).
//  - Divider: P = max(cfg_gap,1)+1; div_cnt counts 0..P-1 while busy; tick when div_cnt==P-1.
//    clk_rd = busy & (div_cnt >= P/2); outputs update on tick so clk_rd rises mid-beat for sampling.
//  - FSM: IDLE -> DATA on start_p|again_p (start wins if both). start_p: ramp=0; again_p: ramp continues.
//    Both clear capture_done, zero sample count and div_cnt, set capture_busy.
//  - DATA: each tick drives adc_data=sample, valid=1, sample count++, beat count++.
//    Sample = cfg_self_test ? ramp (then ramp++, wraps 2^DATA_W-1 -> 0) : adc_in.
//    After data_len+1 beats -> IDLEP if idle_len>0 else stay DATA (new packet).
//  - IDLEP: each tick drives valid=0, adc_data=0; after idle_len beats -> DATA.
//  - When sample count reaches TOTAL_SAMPLES (from DATA or IDLEP boundary): finish the beat, then -> IDLE,
//    valid=0, adc_data=0, busy=0, capture_done=1, clk_rd=0. No trailing idle phase.
//  - start/again edges while busy are ignored (no restart, no abort).
//  - cfg_gap/data_len/idle_len sampled live; changing them mid-run takes effect at the next boundary.
//  - cfg_clk_en=0: counters, FSM, ramp, outputs frozen; edges arriving then are still detected.
//  - Soft/hard reset mid-run aborts immediately to reset values; capture_done stays 0.
// TESTING
//  1 rst 2 cycles -> all outputs 0; no activity with cfg_start=0.
//  2 self_test=1,gap=8,data_len=0,idle_len=15,TOTAL=8; start pulse -> valid 1 beat every 16 beats (144 clk),
//    adc_data 0,1,...,7, clk_rd period 9 clk high 5 cycles; then busy=0, done=1.
//  3 after (2), cfg_again edge -> data 8..15 (ramp continues); cfg_start edge instead -> restarts at 0.
//  4 gap=0 (treated as 1), data_len=3, idle_len=0, self_test=0 -> continuous valid, adc_in captured every 2 clk.
//  5 start while busy ignored; cfg_clk_en=0 mid-packet freezes outputs and counters; resumes exactly.
//  6 cfg_sw_rstn=0 mid-run -> next cycle all outputs 0, FSM IDLE, done=0; ramp wrap 0x3FFFF->0 verified.

Source files
------------

// File: rtl/adc_capture_core.sv
// adc_capture_core
//   Capture/packetizer engine. A rising edge on cfg_start or cfg_again starts a
//   run of TOTAL_SAMPLES data beats. The beats are grouped into packets of
//   cfg_data_len+1 data beats, and each packet is followed by cfg_idle_len idle
//   beats. A beat lasts max(cfg_gap,1)+1 clock cycles. clk_rd is high for the
//   second half of every beat, so the pads are stable when the reader samples.
//
// Ports
//   clk, rst         core clock, synchronous active-high reset
//   adc_in           raw ADC sample, captured on data beats when self-test is off
//   cfg_clk_en       0 freezes the engine (edge detectors keep running)
//   cfg_sw_rstn      0 = synchronous soft reset, same effect as rst
//   cfg_self_test    1 = samples come from an internal wrapping ramp
//   cfg_start        rising edge: fresh capture, ramp restarts at 0
//   cfg_again        rising edge: repeat capture, ramp continues
//   cfg_gap          beat divider, one beat every max(gap,1)+1 cycles
//   cfg_data_len     data beats per packet minus one
//   cfg_idle_len     idle beats after each packet
//   adc_data         registered pad data (0 outside data beats)
//   adc_data_valid   registered, high during data beats
//   clk_rd           registered read strobe
//   capture_busy     run in progress
//   capture_done     sticky completion flag, cleared by the next start/again
module adc_capture_core #(
  parameter int DATA_W        = 18,
  parameter int TOTAL_SAMPLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_in,
  input  logic              cfg_clk_en,
  input  logic              cfg_sw_rstn,
  input  logic              cfg_self_test,
  input  logic              cfg_start,
  input  logic              cfg_again,
  input  logic [7:0]        cfg_gap,
  input  logic [15:0]       cfg_data_len,
  input  logic [15:0]       cfg_idle_len,
  output logic [DATA_W-1:0] adc_data,
  output logic              adc_data_valid,
  output logic              clk_rd,
  output logic              capture_busy,
  output logic              capture_done
);

  localparam int CNT_W = $clog2(TOTAL_SAMPLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_IDLEP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              start_q, again_q;
  logic              pend_start_q, pend_start_d;
  logic              pend_again_q, pend_again_d;
  logic [8:0]        div_q, div_d;
  logic [15:0]       beat_q, beat_d;
  logic [CNT_W-1:0]  smp_q, smp_d;
  logic [DATA_W-1:0] ramp_q, ramp_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              soft_rst;
  logic              start_p, again_p;
  logic              req_start, req_again, req_any;
  logic [8:0]        gap_eff, period, half;
  logic              tick;
  logic              data_end, idle_end, run_end;

  assign soft_rst = rst | ~cfg_sw_rstn;

  assign start_p   = cfg_start & ~start_q;
  assign again_p   = cfg_again & ~again_q;
  // Edges that arrive while frozen are parked until the engine runs again.
  assign req_start = start_p | pend_start_q;
  assign req_again = again_p | pend_again_q;
  assign req_any   = req_start | req_again;

  // A gap of 0 behaves like 1, so a beat is never shorter than two cycles.
  assign gap_eff = (cfg_gap == 8'd0) ? 9'd1 : {1'b0, cfg_gap};
  assign period  = gap_eff + 9'd1;
  assign half    = {1'b0, period[8:1]};
  // >= rather than == so that shrinking cfg_gap mid-beat cannot skip the tick.
  assign tick    = (div_q >= gap_eff);

  assign data_end = (beat_q == cfg_data_len);
  assign idle_end = ((beat_q + 16'd1) == cfg_idle_len);
  assign run_end  = (smp_q == CNT_W'(TOTAL_SAMPLES));

  // Request edge detectors and parking of edges that arrive while frozen.
  always_comb begin
    pend_start_d = 1'b0;
    pend_again_d = 1'b0;
    if (!cfg_clk_en && (state_q == S_IDLE)) begin
      pend_start_d = pend_start_q | start_p;
      pend_again_d = pend_again_q | again_p;
    end else begin
      pend_start_d = 1'b0;
      pend_again_d = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    if (cfg_clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (req_any) state_d = S_DATA;
          else         state_d = S_IDLE;
        end
        S_DATA: begin
          if (!tick)         state_d = S_DATA;
          else if (run_end)  state_d = S_IDLE;
          else if (data_end) state_d = (cfg_idle_len != 16'd0) ? S_IDLEP : S_DATA;
          else               state_d = S_DATA;
        end
        S_IDLEP: begin
          if (!tick)         state_d = S_IDLEP;
          else if (run_end)  state_d = S_IDLE;
          else if (idle_end) state_d = S_DATA;
          else               state_d = S_IDLEP;
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM output / datapath next-state logic.
  always_comb begin
    div_d   = div_q;
    beat_d  = beat_q;
    smp_d   = smp_q;
    ramp_d  = ramp_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = done_q;
    rd_d    = rd_q;
    if (cfg_clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (req_any) begin
            div_d   = 9'd0;
            beat_d  = 16'd0;
            smp_d   = '0;
            done_d  = 1'b0;
            busy_d  = 1'b1;
            data_d  = '0;
            valid_d = 1'b0;
            // Start wins over again when both edges land together.
            ramp_d  = req_start ? '0 : ramp_q;
          end else begin
            div_d   = 9'd0;
          end
        end
        S_DATA, S_IDLEP: begin
          if (!tick) begin
            div_d = div_q + 9'd1;
          end else begin
            div_d = 9'd0;
            if (run_end) begin
              // The last data beat has had its full length; close the run.
              busy_d  = 1'b0;
              done_d  = 1'b1;
              data_d  = '0;
              valid_d = 1'b0;
              beat_d  = 16'd0;
            end else if (state_q == S_DATA) begin
              data_d  = cfg_self_test ? ramp_q : adc_in;
              valid_d = 1'b1;
              smp_d   = smp_q + CNT_W'(1);
              ramp_d  = cfg_self_test ? (ramp_q + DATA_W'(1)) : ramp_q;
              beat_d  = data_end ? 16'd0 : (beat_q + 16'd1);
            end else begin
              data_d  = '0;
              valid_d = 1'b0;
              beat_d  = idle_end ? 16'd0 : (beat_q + 16'd1);
            end
          end
        end
        default: begin
          busy_d  = 1'b0;
          valid_d = 1'b0;
          data_d  = '0;
          div_d   = 9'd0;
        end
      endcase
      // Strobe follows the divider phase of the cycle the register will show.
      rd_d = busy_d & (div_d >= half);
    end else begin
      rd_d = rd_q;
    end
  end

  // Datapath, edge-detector and output registers.
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      start_q      <= 1'b0;
      again_q      <= 1'b0;
      pend_start_q <= 1'b0;
      pend_again_q <= 1'b0;
      div_q        <= 9'd0;
      beat_q       <= 16'd0;
      smp_q        <= '0;
      ramp_q       <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      rd_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      start_q      <= cfg_start;
      again_q      <= cfg_again;
      pend_start_q <= pend_start_d;
      pend_again_q <= pend_again_d;
      div_q        <= div_d;
      beat_q       <= beat_d;
      smp_q        <= smp_d;
      ramp_q       <= ramp_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      rd_q         <= rd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign adc_data       = data_q;
  assign adc_data_valid = valid_q;
  assign clk_rd         = rd_q;
  assign capture_busy   = busy_q;
  assign capture_done   = done_q;

endmodule

// File: tb/tb_adc_capture_core.sv
// Bench for adc_capture_core. Two instances share one set of stimulus:
//   dut_a: DATA_W=18, TOTAL_SAMPLES=8
//   dut_b: DATA_W=4,  TOTAL_SAMPLES=20 (the narrow ramp wraps within a run)
// Expected outputs come from a timing model stated in beats: beat b of a run
// is visible from cycle (b+1)*P to (b+2)*P-1 after the request edge.
module tb_adc_capture_core;

  localparam int TOT_A = 8;
  localparam int TOT_B = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [17:0] adc_in;
  logic        cfg_clk_en, cfg_sw_rstn, cfg_self_test, cfg_start, cfg_again;
  logic [7:0]  cfg_gap;
  logic [15:0] cfg_data_len, cfg_idle_len;

  logic [17:0] a_data;
  logic        a_valid, a_rd, a_busy, a_done;
  logic [3:0]  b_data;
  logic        b_valid, b_rd, b_busy, b_done;

  int checks   = 0;
  int failures = 0;

  int hist [0:16383];
  int base_a, base_b;
  int mp, ml, mi;
  bit mself;

  adc_capture_core #(.DATA_W(18), .TOTAL_SAMPLES(TOT_A)) dut_a (
    .clk(clk), .rst(rst), .adc_in(adc_in),
    .cfg_clk_en(cfg_clk_en), .cfg_sw_rstn(cfg_sw_rstn), .cfg_self_test(cfg_self_test),
    .cfg_start(cfg_start), .cfg_again(cfg_again), .cfg_gap(cfg_gap),
    .cfg_data_len(cfg_data_len), .cfg_idle_len(cfg_idle_len),
    .adc_data(a_data), .adc_data_valid(a_valid), .clk_rd(a_rd),
    .capture_busy(a_busy), .capture_done(a_done)
  );

  adc_capture_core #(.DATA_W(4), .TOTAL_SAMPLES(TOT_B)) dut_b (
    .clk(clk), .rst(rst), .adc_in(adc_in[3:0]),
    .cfg_clk_en(cfg_clk_en), .cfg_sw_rstn(cfg_sw_rstn), .cfg_self_test(cfg_self_test),
    .cfg_start(cfg_start), .cfg_again(cfg_again), .cfg_gap(cfg_gap),
    .cfg_data_len(cfg_data_len), .cfg_idle_len(cfg_idle_len),
    .adc_data(b_data), .adc_data_valid(b_valid), .clk_rd(b_rd),
    .capture_busy(b_busy), .capture_done(b_done)
  );

  // Cycle (relative to the request edge) at which busy drops for a run of tot samples.
  function automatic int capture_end(input int tot);
    int s, g, pos, last_beat;
    s = tot - 1;
    g = s / ml;
    pos = s % ml;
    last_beat = g * (ml + mi) + pos;
    return (last_beat + 2) * mp;
  endfunction

  // Expected outputs at enabled-cycle e of the current run.
  function automatic void model(input int e, input int tot, input int wmask, input int base,
                                output logic busy, output logic valid, output logic rd,
                                output logic done, output int data);
    int b, pos, idx, grp;
    grp = ml + mi;
    if (e >= capture_end(tot)) begin
      busy = 1'b0; valid = 1'b0; rd = 1'b0; done = 1'b1; data = 0;
    end else begin
      busy = 1'b1; done = 1'b0;
      rd = ((e % mp) >= (mp / 2));
      b = (e / mp) - 1;
      valid = 1'b0; data = 0;
      if (b >= 0) begin
        pos = b % grp;
        if (pos < ml) begin
          valid = 1'b1;
          idx = (b / grp) * ml + pos;
          if (mself) data = (base + idx) & wmask;
          else       data = hist[(b + 1) * mp - 1] & wmask;
        end
      end
    end
  endfunction

  // kind: 0 start, 1 again, 2 both. abort_at >= 0 drops cfg_sw_rstn at that cycle.
  task automatic run_capture(input int kind, input int abort_at, input bit poke, input bit freeze);
    int e, iter, end_a, end_b, e_end;
    logic ce, eb, ev, er, ed;
    int edat;
    bit stop;
    mp = (cfg_gap == 8'd0) ? 2 : int'(cfg_gap) + 1;
    ml = int'(cfg_data_len) + 1;
    mi = int'(cfg_idle_len);
    mself = cfg_self_test;
    end_a = capture_end(TOT_A);
    end_b = capture_end(TOT_B);
    e_end = (end_a > end_b) ? end_a : end_b;
    if (kind != 1) begin base_a = 0; base_b = 0; end
    cfg_clk_en = 1'b1;
    cfg_start = (kind != 1);
    cfg_again = (kind != 0);
    @(posedge clk); #1;
    cfg_start = 1'b0; cfg_again = 1'b0;
    e = 0; iter = 0; stop = 1'b0;
    while (!stop && e <= e_end) begin
      model(e, TOT_A, 32'h3FFFF, base_a, eb, ev, er, ed, edat);
      checks++;
      if ({a_busy, a_valid, a_rd, a_done} !== {eb, ev, er, ed} || a_data !== 18'(edat)) begin
        failures++;
        $display("FAIL run_a kind=%0d e=%0d got b/v/r/d=%b%b%b%b data=%0d expected %b%b%b%b data=%0d",
                 kind, e, a_busy, a_valid, a_rd, a_done, a_data, eb, ev, er, ed, edat);
      end
      model(e, TOT_B, 32'hF, base_b, eb, ev, er, ed, edat);
      checks++;
      if ({b_busy, b_valid, b_rd, b_done} !== {eb, ev, er, ed} || b_data !== 4'(edat)) begin
        failures++;
        $display("FAIL run_b kind=%0d e=%0d got b/v/r/d=%b%b%b%b data=%0d expected %b%b%b%b data=%0d",
                 kind, e, b_busy, b_valid, b_rd, b_done, b_data, eb, ev, er, ed, edat);
      end
      cfg_start = 1'b0; cfg_again = 1'b0;
      if (poke && e == 2 * mp) begin cfg_start = 1'b1; cfg_again = 1'b1; end
      adc_in = 18'($urandom);
      hist[e] = int'(adc_in);
      if (freeze && e >= mp && e <= 3 * mp) cfg_clk_en = 1'($urandom_range(0, 1));
      else cfg_clk_en = 1'b1;
      ce = cfg_clk_en;
      if (e == abort_at) cfg_sw_rstn = 1'b0;
      @(posedge clk); #1;
      if (e == abort_at) begin
        checks++;
        if ({a_busy, a_valid, a_rd, a_done, a_data} !== 22'd0) begin
          failures++;
          $display("FAIL abort_a got b/v/r/d=%b%b%b%b data=%0d expected all 0",
                   a_busy, a_valid, a_rd, a_done, a_data);
        end
        checks++;
        if ({b_busy, b_valid, b_rd, b_done, b_data} !== 8'd0) begin
          failures++;
          $display("FAIL abort_b got b/v/r/d=%b%b%b%b data=%0d expected all 0",
                   b_busy, b_valid, b_rd, b_done, b_data);
        end
        cfg_sw_rstn = 1'b1;
        base_a = 0; base_b = 0;
        stop = 1'b1;
      end
      if (ce) e++;
      iter++;
      if (iter > 20000) begin
        failures++;
        $display("FAIL run_timeout got e=%0d expected reach %0d", e, e_end);
        stop = 1'b1;
      end
    end
    cfg_start = 1'b0; cfg_again = 1'b0; cfg_clk_en = 1'b1;
    if (abort_at < 0 && mself) begin
      base_a = (base_a + TOT_A) & 32'h3FFFF;
      base_b = (base_b + TOT_B) & 32'hF;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_busy, a_valid, a_rd, a_done, a_data} !== 22'd0) begin
      failures++;
      $display("FAIL reset_a got %b%b%b%b data=%0d expected all 0", a_busy, a_valid, a_rd, a_done, a_data);
    end
    checks++;
    if ({b_busy, b_valid, b_rd, b_done, b_data} !== 8'd0) begin
      failures++;
      $display("FAIL reset_b got %b%b%b%b data=%0d expected all 0", b_busy, b_valid, b_rd, b_done, b_data);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      adc_in = 18'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({a_busy, a_valid, a_rd, a_done, a_data, b_busy, b_valid, b_rd, b_done, b_data} !== 30'd0) begin
        failures++;
        $display("FAIL idle_no_start cycle=%0d got a=%b%b%b%b/%0d b=%b%b%b%b/%0d expected all 0",
                 i, a_busy, a_valid, a_rd, a_done, a_data, b_busy, b_valid, b_rd, b_done, b_data);
      end
    end
  endtask

  task automatic test_self_test_packets;
    cfg_self_test = 1'b1; cfg_gap = 8'd8; cfg_data_len = 16'd0; cfg_idle_len = 16'd15;
    run_capture(0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_again_and_restart;
    run_capture(1, -1, 1'b0, 1'b0);
    run_capture(0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_gap_zero_adc;
    cfg_self_test = 1'b0; cfg_gap = 8'd0; cfg_data_len = 16'd3; cfg_idle_len = 16'd0;
    run_capture(0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_busy_and_freeze;
    for (int i = 0; i < 4; i++) begin
      cfg_self_test = 1'($urandom_range(0, 1));
      cfg_gap       = 8'($urandom_range(0, 4));
      cfg_data_len  = 16'($urandom_range(0, 5));
      cfg_idle_len  = 16'($urandom_range(0, 4));
      run_capture(i % 3, -1, 1'b1, 1'b1);
    end
  endtask

  task automatic test_soft_reset;
    cfg_self_test = 1'b1; cfg_gap = 8'd2; cfg_data_len = 16'd2; cfg_idle_len = 16'd1;
    run_capture(0, 10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({a_busy, a_valid, a_rd, a_done, a_data, b_busy, b_valid, b_rd, b_done, b_data} !== 30'd0) begin
        failures++;
        $display("FAIL after_abort cycle=%0d got a=%b%b%b%b/%0d b=%b%b%b%b/%0d expected all 0",
                 i, a_busy, a_valid, a_rd, a_done, a_data, b_busy, b_valid, b_rd, b_done, b_data);
      end
    end
  endtask

  task automatic test_ramp_wrap;
    // dut_b emits 0..15 then 0..3 from its 4-bit ramp.
    cfg_self_test = 1'b1; cfg_gap = 8'd1; cfg_data_len = 16'd7; cfg_idle_len = 16'd2;
    run_capture(0, -1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; adc_in = 18'd0;
    cfg_clk_en = 1'b1; cfg_sw_rstn = 1'b1; cfg_self_test = 1'b0;
    cfg_start = 1'b0; cfg_again = 1'b0;
    cfg_gap = 8'd0; cfg_data_len = 16'd0; cfg_idle_len = 16'd0;
    base_a = 0; base_b = 0;
    mp = 2; ml = 1; mi = 0; mself = 1'b0;
    test_reset();
    test_self_test_packets();
    test_again_and_restart();
    test_gap_zero_adc();
    test_busy_and_freeze();
    test_soft_reset();
    test_ramp_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
